// File: rtl/rst_seq_ctrl.sv
// Power-on / software reset sequencer: waits POR_DLY after hw_arst_n release, then
// releases CH_NUM active-low resets STEP_DLY apart; supports global re-sequence and per-channel pulses.
module rst_seq_ctrl #(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned POR_DLY  = 50_000_000,
    parameter int unsigned STEP_DLY = 12_500_000,
    parameter int unsigned HOLD_DLY = 6_250_000
) (
    input  logic              clk_50m,
    input  logic              hw_arst_n,
    input  logic              sw_rst_req,
    input  logic [CH_NUM-1:0] ch_rst_req,
    output logic [CH_NUM-1:0] rst_n_o,
    output logic              seq_done,
    output logic [1:0]        seq_state
);

    typedef enum logic [1:0] {
        S_POR  = 2'd0,
        S_SEQ  = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned HC_W  = $clog2(HOLD_DLY + 1);

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_DLY - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DLY - 1);
    localparam logic [HC_W-1:0]  HC_LOAD   = HC_W'(HOLD_DLY);
    localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CH_NUM - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CH_NUM-1:0] rst_n_q, rst_n_d;
    logic              done_q, done_d;
    logic [HC_W-1:0]   hcnt_q [CH_NUM];
    logic [HC_W-1:0]   hcnt_d [CH_NUM];
    logic              sw_req_q;
    logic [CH_NUM-1:0] ch_req_q;

    logic              sw_rise;
    logic [CH_NUM-1:0] ch_rise;

    assign sw_rise = sw_rst_req & ~sw_req_q;
    assign ch_rise = ch_rst_req & ~ch_req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        hcnt_d  = hcnt_q;

        case (state_q)
            S_POR: begin
                if (cnt_q == POR_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_SEQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEQ: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d          = '0;
                    rst_n_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // A fresh request (re)loads the hold; release happens on the edge seeing hcnt==1.
                for (int unsigned k = 0; k < CH_NUM; k++) begin
                    if (ch_rise[k]) begin
                        rst_n_d[k] = 1'b0;
                        hcnt_d[k]  = HC_LOAD;
                    end else if (hcnt_q[k] == HC_ONE) begin
                        rst_n_d[k] = 1'b1;
                        hcnt_d[k]  = '0;
                    end else if (hcnt_q[k] != '0) begin
                        hcnt_d[k] = hcnt_q[k] - HC_ONE;
                    end
                end
                done_d = &rst_n_d;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_SEQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_POR;
        endcase

        // Software re-sequence overrides everything above, including a same-edge channel request.
        if (sw_rise && (state_q != S_POR)) begin
            state_d = S_HOLD;
            rst_n_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            for (int unsigned k = 0; k < CH_NUM; k++) begin
                hcnt_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge hw_arst_n) begin
        if (!hw_arst_n) begin
            state_q  <= S_POR;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_n_q  <= '0;
            done_q   <= 1'b0;
            hcnt_q   <= '{default: '0};
            sw_req_q <= 1'b0;
            ch_req_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_n_q  <= rst_n_d;
            done_q   <= done_d;
            hcnt_q   <= hcnt_d;
            sw_req_q <= sw_rst_req;
            ch_req_q <= ch_rst_req;
        end
    end

    assign rst_n_o   = rst_n_q;
    assign seq_done  = done_q;
    assign seq_state = state_q;

endmodule
